// File: rtl/seq_trig_pkg.sv
// rtl/seq_trig_pkg.sv - shared FSM type, default AES pattern set and pattern slot helper
package seq_trig_pkg;

  typedef enum logic [1:0] {
    ST_TRACK = 2'd0,
    ST_PULSE = 2'd1,
    ST_DONE  = 2'd2
  } trig_state_e;

  localparam logic [127:0] AES_APPB_PT = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] AES_APPC_PT = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] PAT_ZERO    = 128'h0;
  localparam logic [127:0] PAT_ONE     = 128'h1;

  // Pattern 0 occupies the least-significant slot, so the sequence starts with the AES plaintext.
  localparam logic [511:0] DEFAULT_PATTERNS = {PAT_ONE, PAT_ZERO, AES_APPC_PT, AES_APPB_PT};

  function automatic int unsigned pattern_lsb(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/trig_pulse_gen.sv
// rtl/trig_pulse_gen.sv - fixed-width pulse generator; high for PULSE_LEN cycles after start
module trig_pulse_gen #(
  parameter int unsigned PULSE_LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  output logic trig_o,
  output logic done_o
);

  localparam int unsigned CNT_W = (PULSE_LEN < 1) ? 1 : $clog2(PULSE_LEN + 1);

  logic             active_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= CNT_W'(PULSE_LEN - 1);
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign trig_o = active_q;
  // Asserted during the final high cycle so the owner can leave PULSE on the same edge the pulse drops.
  assign done_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/seq_match_trigger.sv
// rtl/seq_match_trigger.sv - ordered multi-pattern bus watcher that fires a trigger pulse on completion
module seq_match_trigger
  import seq_trig_pkg::*;
#(
  parameter int unsigned               DATA_W    = 128,
  parameter int unsigned               SEQ_LEN   = 4,
  parameter logic [SEQ_LEN*DATA_W-1:0] PATTERNS  = DEFAULT_PATTERNS,
  parameter int unsigned               PULSE_LEN = 2,
  parameter bit                        STRICT    = 1'b0,
  parameter bit                        REARM     = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         state_valid,
  input  logic [DATA_W-1:0]            state,
  output logic                         Tj_Trig,
  output logic [$clog2(SEQ_LEN+1)-1:0] seq_idx,
  output logic                         fired
);

  localparam int unsigned      IDX_W    = $clog2(SEQ_LEN + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);
  localparam logic [IDX_W-1:0] FULL_IDX = IDX_W'(SEQ_LEN);

  logic [DATA_W-1:0] pat [SEQ_LEN];

  for (genvar k = 0; k < SEQ_LEN; k++) begin : g_pat
    assign pat[k] = PATTERNS[pattern_lsb(k, DATA_W) +: DATA_W];
  end

  trig_state_e      fsm_q, fsm_d;
  logic [IDX_W-1:0] seq_idx_q, seq_idx_d;
  logic             fired_q, fired_d;
  logic [DATA_W-1:0] cur_pat;
  logic             is_match, is_first;
  logic             start_pulse, pulse_done, trig;

  always_comb begin
    cur_pat = pat[0];
    for (int k = 1; k < SEQ_LEN; k++) begin
      if (seq_idx_q == IDX_W'(k)) cur_pat = pat[k];
    end
  end

  assign is_match = (state == cur_pat);
  assign is_first = (state == pat[0]);

  always_comb begin
    fsm_d       = fsm_q;
    seq_idx_d   = seq_idx_q;
    fired_d     = fired_q;
    start_pulse = 1'b0;
    case (fsm_q)
      ST_TRACK: begin
        if (state_valid) begin
          if (is_match) begin
            if (seq_idx_q == LAST_IDX) begin
              seq_idx_d   = FULL_IDX;
              fsm_d       = ST_PULSE;
              fired_d     = 1'b1;
              start_pulse = 1'b1;
            end else begin
              seq_idx_d = seq_idx_q + IDX_W'(1);
            end
          end else if (STRICT) begin
            // A broken run may itself be the start of a new one.
            seq_idx_d = is_first ? IDX_W'(1) : '0;
          end
        end
      end
      ST_PULSE: begin
        if (pulse_done) begin
          if (REARM) begin
            fsm_d     = ST_TRACK;
            seq_idx_d = '0;
          end else begin
            fsm_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        fsm_d = ST_DONE;
      end
      default: begin
        fsm_d     = ST_TRACK;
        seq_idx_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q     <= ST_TRACK;
      seq_idx_q <= '0;
      fired_q   <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      seq_idx_q <= seq_idx_d;
      fired_q   <= fired_d;
    end
  end

  trig_pulse_gen #(
    .PULSE_LEN(PULSE_LEN)
  ) u_pulse (
    .clk    (clk),
    .rst    (rst),
    .start_i(start_pulse),
    .trig_o (trig),
    .done_o (pulse_done)
  );

  assign Tj_Trig = trig;
  assign seq_idx = seq_idx_q;
  assign fired   = fired_q;

endmodule

// File: tb/tb_seq_match_trigger.sv
// tb/tb_seq_match_trigger.sv - self-checking bench over four trigger configurations
module tb_seq_match_trigger;

  localparam logic [127:0] P0 = 128'h3243f6a8_885a308d_313198a2_e0370734;
  localparam logic [127:0] P1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam int NCFG = 4;

  logic         clk;
  logic         rst, valid;
  logic [127:0] st;
  logic         trig0, trig1, trig2, trig3;
  logic         fired0, fired1, fired2, fired3;
  logic [2:0]   idx0, idx1, idx2;
  logic         idx3;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: progress count, remaining pulse cycles, sticky flags per configuration.
  int           cfg_n      [NCFG] = '{4, 4, 4, 1};
  int           cfg_pl     [NCFG] = '{2, 2, 3, 2};
  bit           cfg_strict [NCFG] = '{1'b0, 1'b1, 1'b0, 1'b0};
  bit           cfg_rearm  [NCFG] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [127:0] pats [NCFG][4];
  int           m_prog  [NCFG];
  int           m_left  [NCFG];
  bit           m_fired [NCFG];
  bit           m_fin   [NCFG];

  logic         got_trig  [NCFG];
  logic         got_fired [NCFG];
  logic [31:0]  got_idx   [NCFG];

  always_comb begin
    got_trig[0] = trig0;  got_trig[1] = trig1;  got_trig[2] = trig2;  got_trig[3] = trig3;
    got_fired[0] = fired0; got_fired[1] = fired1; got_fired[2] = fired2; got_fired[3] = fired3;
    got_idx[0] = 32'(idx0); got_idx[1] = 32'(idx1); got_idx[2] = 32'(idx2); got_idx[3] = 32'(idx3);
  end

  seq_match_trigger u_def (
    .clk(clk), .rst(rst), .state_valid(valid), .state(st),
    .Tj_Trig(trig0), .seq_idx(idx0), .fired(fired0)
  );

  seq_match_trigger #(.STRICT(1'b1)) u_strict (
    .clk(clk), .rst(rst), .state_valid(valid), .state(st),
    .Tj_Trig(trig1), .seq_idx(idx1), .fired(fired1)
  );

  seq_match_trigger #(.PULSE_LEN(3), .REARM(1'b1)) u_rearm (
    .clk(clk), .rst(rst), .state_valid(valid), .state(st),
    .Tj_Trig(trig2), .seq_idx(idx2), .fired(fired2)
  );

  seq_match_trigger #(.SEQ_LEN(1), .PATTERNS(128'h1)) u_one (
    .clk(clk), .rst(rst), .state_valid(valid), .state(st),
    .Tj_Trig(trig3), .seq_idx(idx3), .fired(fired3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_adv(input int c, input bit r, input bit v, input logic [127:0] s);
    if (r) begin
      m_prog[c] = 0; m_left[c] = 0; m_fired[c] = 1'b0; m_fin[c] = 1'b0;
    end else if (m_left[c] > 0) begin
      m_left[c]--;
      if (m_left[c] == 0) begin
        if (cfg_rearm[c]) m_prog[c] = 0;
        else m_fin[c] = 1'b1;
      end
    end else if (!m_fin[c] && v) begin
      if (s == pats[c][m_prog[c]]) begin
        m_prog[c]++;
        if (m_prog[c] == cfg_n[c]) begin
          m_left[c]  = cfg_pl[c];
          m_fired[c] = 1'b1;
        end
      end else if (cfg_strict[c]) begin
        m_prog[c] = (s == pats[c][0]) ? 1 : 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [127:0] s);
    rst = r; valid = v; st = s;
    @(posedge clk);
    #1;
    for (int c = 0; c < NCFG; c++) model_adv(c, r, v, s);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, '0);
    for (int c = 0; c < NCFG; c++) begin
      n_tests++;
      if (got_trig[c] !== 1'b0 || got_idx[c] !== 32'd0 || got_fired[c] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset cfg%0d: trig=%b idx=%0d fired=%b, need 0 0 0",
                 c, got_trig[c], got_idx[c], got_fired[c]);
      end
    end
  endtask

  task automatic test_default_seq();
    logic [127:0] seq [4];
    seq = '{P0, P1, 128'h0, 128'h1};
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, seq[i]);
      n_tests++;
      if (idx0 !== 3'(i + 1) || trig0 !== 1'(i == 3)) begin
        n_fail++;
        $display("FAIL default_seq s%0d: idx=%0d trig=%b, need idx=%0d trig=%b", i, idx0, trig0, i + 1, i == 3);
      end
    end
    step(1'b0, 1'b0, '0);
    n_tests++;
    if (trig0 !== 1'b1) begin n_fail++; $display("FAIL default_pulse2: trig=%b need 1", trig0); end
    step(1'b0, 1'b0, '0);
    n_tests++;
    if (trig0 !== 1'b0 || idx0 !== 3'd4 || fired0 !== 1'b1) begin
      n_fail++;
      $display("FAIL default_end: trig=%b idx=%0d fired=%b, need 0 4 1", trig0, idx0, fired0);
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, seq[i % 4]);
      n_tests++;
      if (trig0 !== 1'b0 || idx0 !== 3'd4) begin
        n_fail++;
        $display("FAIL default_no_refire s%0d: trig=%b idx=%0d, need 0 4", i, trig0, idx0);
      end
    end
  endtask

  task automatic test_relaxed_junk();
    bit           vv [6];
    logic [127:0] ss [6];
    int           ei [6];
    vv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    ss = '{P0, 128'hAA, P1, 128'h0, 128'h0, 128'h1};
    ei = '{1, 1, 2, 2, 3, 4};
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, vv[i], ss[i]);
      n_tests++;
      if (idx0 !== 3'(ei[i]) || trig0 !== 1'(i == 5)) begin
        n_fail++;
        $display("FAIL relaxed s%0d: idx=%0d trig=%b, need idx=%0d trig=%b", i, idx0, trig0, ei[i], i == 5);
      end
    end
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    n_tests++;
    if (trig0 !== 1'b0 || fired0 !== 1'b1) begin
      n_fail++;
      $display("FAIL relaxed_end: trig=%b fired=%b, need 0 1", trig0, fired0);
    end
  endtask

  task automatic test_strict();
    logic [127:0] ss [8];
    int           ei [8];
    ss = '{P0, P1, 128'h5, 128'h0, 128'h1, P0, P1, P0};
    ei = '{1, 2, 0, 0, 0, 1, 2, 1};
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, ss[i]);
      n_tests++;
      if (idx1 !== 3'(ei[i]) || trig1 !== 1'b0) begin
        n_fail++;
        $display("FAIL strict s%0d: idx=%0d trig=%b, need idx=%0d trig=0", i, idx1, trig1, ei[i]);
      end
    end
    n_tests++;
    if (fired1 !== 1'b0) begin n_fail++; $display("FAIL strict_fired: fired=%b need 0", fired1); end
  endtask

  task automatic test_rearm();
    logic [127:0] seq [4];
    int hi;
    seq = '{P0, P1, 128'h0, 128'h1};
    step(1'b1, 1'b0, '0);
    for (int run = 0; run < 2; run++) begin
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, seq[i]);
      hi = 0;
      for (int j = 0; j < 4; j++) begin
        if (trig2 === 1'b1) hi++;
        step(1'b0, 1'b1, seq[j]);
      end
      n_tests++;
      if (hi != 3 || trig2 !== 1'b0 || idx2 !== 3'd0 || fired2 !== 1'b1) begin
        n_fail++;
        $display("FAIL rearm run%0d: pulse_cycles=%0d trig=%b idx=%0d fired=%b, need 3 0 0 1",
                 run, hi, trig2, idx2, fired2);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [127:0] seq [4];
    seq = '{P0, P1, 128'h0, 128'h1};
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, seq[i]);
    step(1'b0, 1'b0, '0);
    n_tests++;
    if (trig0 !== 1'b1 || trig2 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: trig_def=%b trig_rearm=%b, need 1 1", trig0, trig2);
    end
    step(1'b1, 1'b0, '0);
    n_tests++;
    if (trig2 !== 1'b0 || idx2 !== 3'd0 || fired2 !== 1'b0 ||
        trig0 !== 1'b0 || idx0 !== 3'd0 || fired0 !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_cut: rearm trig=%b idx=%0d fired=%b def trig=%b idx=%0d fired=%b, need all 0",
               trig2, idx2, fired2, trig0, idx0, fired0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, seq[i]);
    n_tests++;
    if (trig0 !== 1'b1 || idx0 !== 3'd4 || fired0 !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_refire: trig=%b idx=%0d fired=%b, need 1 4 1", trig0, idx0, fired0);
    end
  endtask

  task automatic test_seq_len_one();
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 128'h5);
    n_tests++;
    if (trig3 !== 1'b0 || idx3 !== 1'b0) begin
      n_fail++; $display("FAIL one_miss: trig=%b idx=%0d, need 0 0", trig3, idx3);
    end
    step(1'b0, 1'b0, 128'h1);
    n_tests++;
    if (trig3 !== 1'b0 || idx3 !== 1'b0) begin
      n_fail++; $display("FAIL one_invalid: trig=%b idx=%0d, need 0 0", trig3, idx3);
    end
    step(1'b0, 1'b1, 128'h1);
    n_tests++;
    if (trig3 !== 1'b1 || idx3 !== 1'b1 || fired3 !== 1'b1) begin
      n_fail++; $display("FAIL one_fire: trig=%b idx=%0d fired=%b, need 1 1 1", trig3, idx3, fired3);
    end
  endtask

  task automatic test_random();
    bit           r, v;
    int           c, k, sel;
    logic [127:0] s;
    step(1'b1, 1'b0, '0);
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 299) == 0);
      v   = ($urandom_range(0, 3) != 0);
      c   = $urandom_range(0, NCFG - 1);
      k   = (m_prog[c] < cfg_n[c]) ? m_prog[c] : 0;
      sel = $urandom_range(0, 9);
      if (sel < 6)      s = pats[c][k];
      else if (sel < 8) s = pats[c][0];
      else              s = {$urandom, $urandom, $urandom, $urandom};
      step(r, v, s);
      for (int d = 0; d < NCFG; d++) begin
        n_tests++;
        if (got_trig[d] !== 1'(m_left[d] > 0)) begin
          n_fail++;
          $display("FAIL random n%0d cfg%0d trig: got %b want %b", n, d, got_trig[d], m_left[d] > 0);
        end
        n_tests++;
        if (got_idx[d] !== 32'(m_prog[d])) begin
          n_fail++;
          $display("FAIL random n%0d cfg%0d seq_idx: got %0d want %0d", n, d, got_idx[d], m_prog[d]);
        end
        n_tests++;
        if (got_fired[d] !== m_fired[d]) begin
          n_fail++;
          $display("FAIL random n%0d cfg%0d fired: got %b want %b", n, d, got_fired[d], m_fired[d]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; st = '0;
    for (int c = 0; c < 3; c++) pats[c] = '{P0, P1, 128'h0, 128'h1};
    pats[3] = '{128'h1, 128'h0, 128'h0, 128'h0};
    for (int c = 0; c < NCFG; c++) begin
      m_prog[c] = 0; m_left[c] = 0; m_fired[c] = 1'b0; m_fin[c] = 1'b0;
    end
    test_reset();
    test_default_seq();
    test_relaxed_junk();
    test_strict();
    test_rearm();
    test_reset_mid_pulse();
    test_seq_len_one();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_match_trigger.md
Name: seq_match_trigger

Overview:
- Parametrised successor of the single-shot AES state-sequence trigger.
- Watches a DATA_W-bit observed bus for an ordered sequence of SEQ_LEN patterns and, on completion, asserts Tj_Trig for PULSE_LEN cycles.
- Adds a sample-valid qualifier, strict/relaxed sequence modes, a re-arm option and progress status.
- Sits beside the AES core in the Trojan-benchmark (TjIn) variants and taps the round-state bus.

Parameters:
- DATA_W, 128, width of observed bus and of each pattern.
- SEQ_LEN, 4, number of patterns in the sequence (1..16).
- PATTERNS, {128'h3243f6a8_885a308d_313198a2_e0370734, 128'h00112233_44556677_8899aabb_ccddeeff, 128'h0, 128'h1}, packed SEQ_LEN*DATA_W vector; pattern k occupies bits [k*DATA_W +: DATA_W].
- PULSE_LEN, 2, trigger pulse width in cycles (>=1).
- STRICT, 0, 0 = mismatching samples ignored; 1 = mismatching sample restarts the sequence.
- REARM, 0, 0 = fire once until reset; 1 = return to idle after the pulse.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- state_valid  in  1  qualifies state; unqualified cycles never advance or restart the sequence.
- state  in  DATA_W  observed bus.
- Tj_Trig  out  1  registered trigger pulse.
- seq_idx  out  $clog2(SEQ_LEN+1)  number of patterns matched so far.
- fired  out  1  sticky: at least one pulse issued since reset.

Behaviour:
- All outputs are registered. Reset is synchronous on rst=1 at the clk edge. After reset: Tj_Trig=0, seq_idx=0, fired=0, FSM=IDLE, pulse counter=0. Reset mid-pulse ends the pulse at that edge.
- FSM states are IDLE/TRACK, PULSE and DONE.
- TRACK: on state_valid=1 and state==pattern[seq_idx], seq_idx increments.
- TRACK, STRICT=1 mismatch (valid but not equal to pattern[seq_idx]): if state==pattern[0], seq_idx becomes 1; otherwise seq_idx becomes 0.
- TRACK, STRICT=0 mismatch: seq_idx holds.
- Final match (seq_idx==SEQ_LEN-1 and match):
  - next edge: seq_idx=SEQ_LEN, FSM=PULSE, Tj_Trig=1, pulse counter loads PULSE_LEN-1, fired=1.
  - Latency is 1 cycle from the final matching sample to Tj_Trig high.
- PULSE: Tj_Trig stays 1 for exactly PULSE_LEN cycles while the counter decrements. state/state_valid are ignored.
- End of PULSE: Tj_Trig=0. If REARM=1, FSM goes to TRACK with seq_idx=0. If REARM=0, FSM goes to DONE with seq_idx held at SEQ_LEN.
- DONE: inputs are ignored; only rst exits.
- Duplicate patterns: pattern[k]==pattern[k+1] requires two separate valid samples. One sample advances at most one step per cycle.
- SEQ_LEN=1: the first valid match fires.
- Comparison is full-width equality; there are no don't-care bits.
- Counter widths: seq_idx uses $clog2(SEQ_LEN+1); the pulse counter uses $clog2(PULSE_LEN+1). No wrap is possible because both counters saturate at their bounds.

Decomposition:
- Package seq_trig_pkg:
  - FSM state enum (ST_TRACK, ST_PULSE, ST_DONE).
  - Default AES test-vector pattern constants.
  - Helper function extracting pattern k from the packed vector.
- Sub-module trig_pulse_gen:
  - Loads on start and drives Tj_Trig for PULSE_LEN cycles.
  - Reports done.
  - Has synchronous rst.

Test Plan:
- Defaults. Apply valid samples P0, P1, 0, 1 on consecutive cycles → Tj_Trig=1 exactly at edges 5 and 6 (2 cycles), seq_idx=4, fired=1. Further P0..P3 produce no second pulse (REARM=0).
- Defaults, STRICT=0. Apply P0, 0xAA, P1, (valid=0 with state=0), 0, 1 → trigger fires once; the junk sample and the invalid cycle are ignored, and seq_idx steps 1, 1, 2, 2, 3, 4.
- STRICT=1. Apply P0, P1, 0x5, 0, 1 → seq_idx returns to 0 on 0x5, and no trigger fires. Then apply P0, P1, P0 → seq_idx=1 (restart on pattern[0]).
- REARM=1, PULSE_LEN=3. Run the full sequence twice → two 3-cycle pulses. Samples presented during the pulse are ignored, and seq_idx=0 after each pulse.
- rst=1 on the 2nd pulse cycle → at the next edge Tj_Trig=0, seq_idx=0, fired=0. A full sequence afterwards fires again.
- SEQ_LEN=1, PATTERNS=128'h1. One valid sample of 1 → pulse 1 cycle later; a sample of 1 with valid=0 → no pulse.
